// File: rtl/sblk_loader.sv
// SuperBlock stream loader: deals one valid/ready word stream round-robin across NTILE
// SuperTile weight memories, then activation memories, once per cfg_start.
module sblk_loader #(
  parameter int NTILE       = 4,
  parameter int W_BIT       = 16,
  parameter int ACT_BIT     = 16,
  parameter int DATA_BIT    = 16,
  parameter int WADDR_BIT   = 10,
  parameter int ACTADDR_BIT = 6
) (
  input  logic                     clk_l,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [WADDR_BIT:0]       cfg_n_w,
  input  logic [ACTADDR_BIT:0]     cfg_n_act,
  input  logic [DATA_BIT-1:0]      s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [NTILE*W_BIT-1:0]   w_wr_data,
  output logic [NTILE-1:0]         w_wr_en,
  output logic [WADDR_BIT-1:0]     w_wr_addr,
  output logic [NTILE*ACT_BIT-1:0] act_wr_data,
  output logic [NTILE-1:0]         act_wr_en,
  output logic [ACTADDR_BIT-1:0]   act_wr_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int TW = $clog2(NTILE);
  localparam int AW = (WADDR_BIT > ACTADDR_BIT) ? WADDR_BIT : ACTADDR_BIT;
  localparam logic [WADDR_BIT:0]   W_MAX   = {1'b1, {WADDR_BIT{1'b0}}};
  localparam logic [ACTADDR_BIT:0] ACT_MAX = {1'b1, {ACTADDR_BIT{1'b0}}};
  localparam logic [NTILE-1:0]     EN_ONE  = {{(NTILE-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_ACT, DONE} state_t;

  state_t               state, state_nx;
  logic [WADDR_BIT:0]   n_w, n_w_clamp;
  logic [ACTADDR_BIT:0] n_act, n_act_clamp;
  logic [TW-1:0]        t;
  logic [AW-1:0]        a;
  logic [AW:0]          n_cur;
  logic                 accept, tile_last, last_beat;

  assign n_w_clamp   = (cfg_n_w > W_MAX) ? W_MAX : cfg_n_w;
  assign n_act_clamp = (cfg_n_act > ACT_MAX) ? ACT_MAX : cfg_n_act;

  // Outputs decode the state register only, so s_ready never depends on s_valid.
  assign s_ready = (state == LOAD_W) || (state == LOAD_ACT);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  assign accept    = s_valid && s_ready;
  assign n_cur     = (state == LOAD_W) ? (AW+1)'(n_w) : (AW+1)'(n_act);
  assign tile_last = (t == TW'(NTILE - 1));
  assign last_beat = accept && tile_last && ({1'b0, a} == n_cur - 1'b1);

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_l) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          if (n_w_clamp != '0)        state_nx = LOAD_W;
          else if (n_act_clamp != '0) state_nx = LOAD_ACT;
          else                        state_nx = DONE;
        end
      end
      LOAD_W: begin
        if (last_beat) state_nx = (n_act != '0) ? LOAD_ACT : DONE;
      end
      LOAD_ACT: begin
        if (last_beat) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Counters and config; the tile counter wraps first, the address advances on each wrap.
  always_ff @(posedge clk_l) begin
    if (rst) begin
      n_w   <= '0;
      n_act <= '0;
      t     <= '0;
      a     <= '0;
    end else if (state == IDLE) begin
      t <= '0;
      a <= '0;
      if (cfg_start) begin
        n_w   <= n_w_clamp;
        n_act <= n_act_clamp;
      end
    end else if (accept) begin
      if (last_beat) begin
        t <= '0;
        a <= '0;
      end else if (tile_last) begin
        t <= '0;
        a <= a + 1'b1;
      end else begin
        t <= t + 1'b1;
      end
    end
  end

  // Write port: enables pulse one cycle after an accept; data and address hold otherwise.
  always_ff @(posedge clk_l) begin
    if (rst) begin
      w_wr_en     <= '0;
      w_wr_addr   <= '0;
      w_wr_data   <= '0;
      act_wr_en   <= '0;
      act_wr_addr <= '0;
      act_wr_data <= '0;
    end else begin
      w_wr_en   <= '0;
      act_wr_en <= '0;
      if (accept && state == LOAD_W) begin
        w_wr_en   <= EN_ONE << t;
        w_wr_addr <= a[WADDR_BIT-1:0];
        w_wr_data <= {NTILE{s_data[W_BIT-1:0]}};
      end
      if (accept && state == LOAD_ACT) begin
        act_wr_en   <= EN_ONE << t;
        act_wr_addr <= a[ACTADDR_BIT-1:0];
        act_wr_data <= {NTILE{s_data[ACT_BIT-1:0]}};
      end
    end
  end

endmodule
